// File: rtl/vec_resp_checker.sv
// rtl/vec_resp_checker.sv - expected-vector store and cycle-accurate DUT response checker
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   load_valid/data      expected vector write beat; load_ready accepts it (IDLE only)
//   start                begin a check pass over the stored vectors
//   sample_en, dut_out   compare dut_out against the next stored vector
//   clear                leave DONE and empty the store
//   busy, done, pass     CHECK state, DONE state, DONE with zero mismatches
//   err_count            saturating mismatch count of the current/last pass
//   first_fail_idx/val   index and dut_out value of the first mismatch
//   fail_seen            at least one mismatch in this pass
module vec_resp_checker #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 16,
    parameter int CNT_W = 8,
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int PTR_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    input  logic             start,
    input  logic             sample_en,
    input  logic [WIDTH-1:0] dut_out,
    input  logic             clear,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [IDX_W-1:0] first_fail_idx,
    output logic [WIDTH-1:0] first_fail_val,
    output logic             fail_seen
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    logic             load_fire;
    logic             mismatch;
    logic             last_sample;

    // Pointers can reach DEPTH, so they carry one extra bit over the index.
    assign load_ready  = (state == S_IDLE) && (wr_ptr < PTR_W'(DEPTH)) && !start;
    assign load_fire   = load_valid && load_ready;
    assign mismatch    = sample_en && (dut_out != mem[rd_ptr[IDX_W-1:0]]);
    assign last_sample = sample_en && (rd_ptr == wr_ptr - PTR_W'(1));

    assign busy = (state == S_CHECK);
    assign done = (state == S_DONE);
    assign pass = done && (err_count == '0);

    // Vector storage is not reset; wr_ptr=0 is what marks it empty.
    always_ff @(posedge clk) begin
        if (load_fire) begin
            mem[wr_ptr[IDX_W-1:0]] <= load_data;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = (wr_ptr != '0) ? S_CHECK : S_DONE;
                end
            end
            S_CHECK: begin
                if (last_sample) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (clear) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            err_count      <= '0;
            first_fail_idx <= '0;
            first_fail_val <= '0;
            fail_seen      <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        // Results of the previous pass survive clear and are
                        // only dropped here.
                        rd_ptr         <= '0;
                        err_count      <= '0;
                        first_fail_idx <= '0;
                        first_fail_val <= '0;
                        fail_seen      <= 1'b0;
                    end else if (load_fire) begin
                        wr_ptr <= wr_ptr + PTR_W'(1);
                    end
                end
                S_CHECK: begin
                    if (sample_en) begin
                        rd_ptr <= rd_ptr + PTR_W'(1);
                    end
                    if (mismatch) begin
                        if (err_count != '1) begin
                            err_count <= err_count + CNT_W'(1);
                        end
                        if (!fail_seen) begin
                            first_fail_idx <= rd_ptr[IDX_W-1:0];
                            first_fail_val <= dut_out;
                            fail_seen      <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (clear) begin
                        wr_ptr <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/vec_resp_checker.md
Name: vec_resp_checker

Overview:
- Response-side companion to our directed-vector benches: stores a list of expected DUT output vectors, then samples the live DUT output and compares it against that list one vector at a time.
- Reports the error count, the first failing index and value, and a pass/fail flag.
- Sits between the DUT output (e.g. Z of a standard cell under test) and bench/scan control logic, so checking is cycle-accurate in hardware rather than by waveform inspection.

Parameters:
- WIDTH, 1, width of one DUT output vector.
- DEPTH, 16, maximum number of expected vectors stored.
- CNT_W, 8, width of the error counter; the counter saturates at its maximum.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- load_valid  input  1  an expected vector is presented on load_data.
- load_data  input  WIDTH  expected vector value.
- load_ready  output  1  the checker can accept an expected vector this cycle.
- start  input  1  begin the check pass (one-cycle pulse).
- sample_en  input  1  dut_out is settled and must be compared this cycle.
- dut_out  input  WIDTH  DUT output under check.
- clear  input  1  leave DONE and empty the vector store.
- busy  output  1  the checker is in CHECK.
- done  output  1  the checker is in DONE.
- pass  output  1  valid when done=1; equals (err_count==0).
- err_count  output  CNT_W  number of mismatches in the current or last pass.
- first_fail_idx  output  clog2(DEPTH)  index of the first mismatch.
- first_fail_val  output  WIDTH  dut_out value captured at the first mismatch.
- fail_seen  output  1  at least one mismatch has occurred in this pass.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE, wr_ptr=0, rd_ptr=0.
  - err_count=0, first_fail_idx=0, first_fail_val=0, fail_seen=0.
  - busy=0, done=0, pass=0.
  - Reset applied in any state, including mid-CHECK, aborts the pass with no partial result retained.
  - Storage contents need not be reset; wr_ptr=0 makes the store empty.
- States: IDLE, CHECK, DONE.
- IDLE:
  - load_ready = (wr_ptr<DEPTH) && !start (combinational).
  - A load_valid&&load_ready beat writes mem[wr_ptr]<=load_data and increments wr_ptr.
  - When the store is full (wr_ptr==DEPTH), load_ready=0 and further beats are not accepted.
  - start with wr_ptr>0: go to CHECK; rd_ptr<=0; err_count, fail_seen and first_fail_* cleared.
  - start with wr_ptr==0: go directly to DONE with err_count=0, so pass=1.
  - start and load_valid in the same cycle: start wins; the load beat is not accepted (load_ready=0).
- CHECK:
  - busy=1 and load_ready=0.
  - On sample_en, compare dut_out against mem[rd_ptr] (full-width equality).
  - On a mismatch, increment err_count, saturating at 2^CNT_W-1.
  - On a mismatch with fail_seen=0, also capture first_fail_idx<=rd_ptr and first_fail_val<=dut_out, and set fail_seen<=1.
  - rd_ptr increments on every sample_en.
  - On a sample with rd_ptr==wr_ptr-1, the pass ends: go to DONE the next cycle, with the last comparison already reflected in err_count.
  - Cycles without sample_en hold all state. There is no timeout.
  - start and clear are ignored in CHECK.
- DONE:
  - done=1, pass=(err_count==0), busy=0.
  - All results hold stable until clear.
  - clear: go to IDLE, wr_ptr<=0; results persist until the next start.
  - start is ignored in DONE.
- Latency:
  - A compare result is visible on err_count in the cycle after its sample_en edge.
  - done rises one cycle after the final sample.
- Combinational outputs: only load_ready depends combinationally on inputs (start); all other outputs are registered or decoded from state.

Test Plan:
- Inverter check, all pass: WIDTH=1; load expected 1,0,1,0,1; start; drive dut_out=1,0,1,0,1 with sample_en on 5 cycles -> done=1 one cycle after the 5th sample, pass=1, err_count=0, fail_seen=0.
- Mismatches: same load; dut_out=1,1,1,0,0 -> err_count=2, first_fail_idx=1, first_fail_val=1, pass=0.
- Full store, empty start, saturation: DEPTH=4; offer 6 load beats -> only 4 accepted and load_ready=0 after the 4th. Separately, clear and then start with an empty store -> DONE, pass=1. With CNT_W=2 and 4 mismatches -> err_count=3 (saturated).
- Idle cycles and collisions: sample_en low for 3 cycles mid-pass -> rd_ptr and err_count hold. A start+load_valid collision in IDLE -> load not accepted and CHECK entered. start pulsed in CHECK or DONE -> no effect.
- Reset and reuse: rst after 2 of 5 samples -> all outputs at reset values and load_ready=1. Reload 3 vectors and rerun -> correct independent result. In DONE, clear then start without reloading -> immediate DONE, pass=1.
